seq_alu_param: RTL and testbench
================================

// Module: seq_alu_param
// PURPOSE
//  Parametrised multi-cycle sequential ALU; successor to the fixed 8-bit datapath ALU.
//  Performs signed add/sub, signed Booth radix-2 multiply and unsigned non-restoring divide on WIDTH-bit operands.
//  Operands enter over a shared input bus in two beats; results leave on a 2*WIDTH output bus, tagged by a finish pulse.
//  Adds a busy output and defined divide-by-zero / quotient-overflow handling.
// PARAMETERS
//  WIDTH  8  operand width in bits (>=4); inbus/outbus are 2*WIDTH
// PORTS
//  clk     in   1        single clock, rising edge
//  rst     in   1        asynchronous, active-high reset
//  start   in   1        begin operation; sampled only in IDLE
//  sel     in   2        00 add, 01 sub, 10 mul, 11 div; latched with start
//  inbus   in   2*WIDTH  beat1 operand (with start), beat2 M (next cycle)
//  outbus  out  2*WIDTH  result register; held until next finish
//  finish  out  1        one-cycle pulse: outbus valid this cycle
//  busy    out  1        high from cycle after start until finish, inclusive
// BEHAVIOUR
//  Reset: state=IDLE, outbus=0, finish=0, busy=0; A,Q,M,q_m1,count cleared. Reset mid-op aborts, no finish.
//  FSM: IDLE -start-> LOADM -> EXEC -> (ITER xWIDTH for mul/div) -> [CORR div only] -> DONE -> IDLE.
//  Beat1 (start cycle): add/sub/mul: A/Q <= inbus[WIDTH-1:0]; div: {A,Q} <= inbus (2*WIDTH dividend).
//  Beat2 (LOADM): M <= inbus[WIDTH-1:0]; upper inbus bits ignored.
//  start while busy is ignored; sel/inbus outside beats are don't-care.
//  add/sub: one-cycle EXEC; outbus = sign-extended WIDTH-bit result (wraps mod 2^WIDTH).
//  mul: Booth on {A,Q,q_m1}: 01 add M, 10 sub M, then arithmetic right shift; outbus={A,Q}, signed 2*WIDTH.
//  div: non-restoring, unsigned; per step shift {A,Q} left, add/sub M by sign of A; Q[0]=~sign.
//   CORR: if A negative, A += M. outbus = {remainder, quotient}.
//   M==0 or dividend[2W-1:W] >= M: skip ITER; outbus={dividend[2W-1:W], {WIDTH{1'b1}}}.
//  Latency start edge -> finish: add/sub 3, mul WIDTH+3, div WIDTH+4, div exception 3 cycles.
//  Step counter: WIDTH iterations exactly, terminal flag at count==WIDTH-1; cleared in LOADM.
//  Internal adder is WIDTH+1 bits wide (sign guard bit); subtraction = add ~M with cin=1.
//  outbus updated only in DONE; finish high only in DONE; busy low in IDLE.
// CONFIGURATION
//  SEQ_ALU_STATUS_EN defined: adds port status out 2 = {ovf, dz}, valid with finish, held with outbus, reset 0.
//   ovf: signed add/sub overflow or div quotient overflow; dz: divide by zero (ovf=0 then).
//  Undefined: no status port; results identical.
// STRUCTURE
//  alu_pkg: opcode constants (OP_ADD..OP_DIV), FSM state encoding, result-packing helpers.
//  Sub-module alu_step_counter: parametrised clear/increment counter, log2 width, terminal-count output.
//  Top holds FSM, A/Q/M/q_m1 registers, shared adder, output register.
// TESTING (WIDTH=8 unless noted)
//  add 40,12 -> finish at +3, outbus=16'd52; sub 40,12 -> 16'd28; sub 12,40 -> 16'hFFE4.
//  mul 40,12 -> finish at +11, outbus=16'd480; mul -3,5 -> 16'hFFF1; mul -128,-128 -> 16'h4000.
//  div 11542/135 -> finish at +12, outbus={8'd67,8'd85}=16'h4355.
//  div 100/0 -> finish at +3, outbus=16'h00FF; with SEQ_ALU_STATUS_EN status=2'b01.
//  rst pulsed mid-mul -> outbus=0, busy=0, no finish; new add 1,1 afterwards -> 16'd2.
//  WIDTH=16: mul 300,-2 -> 32'hFFFF_FDA8 at +19; start pulsed while busy has no effect.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for seq_alu_param: opcodes, FSM state encoding and
// small result-packing helpers.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOADM,
    S_EXEC,
    S_ITER,
    S_CORR,
    S_DONE
  } state_t;

  function automatic logic is_iterative(input op_t op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic [1:0] pack_status(input logic ovf, input logic dz);
    return {ovf, dz};
  endfunction

endpackage

// File: rtl/alu_step_counter.sv
// Clear/increment step counter; last is high while count == N-1.
module alu_step_counter #(
  parameter int N = 8,
  localparam int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic last
);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      count <= '0;
    else if (clr) count <= '0;
    else if (inc) count <= count + 1'b1;
  end

  assign last = (count == CW'(N - 1));

endmodule

// File: rtl/seq_alu_param.sv
// Multi-cycle ALU: signed add/sub, Booth radix-2 multiply, unsigned non-restoring divide.
// Define SEQ_ALU_STATUS_EN to add the status = {ovf, dz} output.
module seq_alu_param
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           sel,
  input  logic [2*WIDTH-1:0]   inbus,
  output logic [2*WIDTH-1:0]   outbus,
  output logic                 finish,
  output logic                 busy
`ifdef SEQ_ALU_STATUS_EN
  ,
  output logic [1:0]           status
`endif
);

  state_t           state, state_nx;
  op_t              op;
  logic [WIDTH:0]   a;      // one guard bit above the WIDTH-bit accumulator
  logic [WIDTH-1:0] q, m;
  logic             q_m1;
  logic             exc;
  logic             step_last;
  logic             accept;
  logic             div_exc;

  logic [WIDTH:0]   add_a, add_b, sum;
  logic             add_sub;
  logic [2*WIDTH-1:0] result;

  // start arriving in the finish cycle is still treated as busy
  assign accept  = (state == S_IDLE) && start && !finish;
  assign div_exc = (m == '0) || (a[WIDTH-1:0] >= m);
  assign busy    = (state != S_IDLE) || finish;

  alu_step_counter #(.N(WIDTH)) u_step (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == S_LOADM),
    .inc  (state == S_ITER),
    .last (step_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = S_LOADM;
      S_LOADM: state_nx = S_EXEC;
      S_EXEC: begin
        if (op == OP_DIV)          state_nx = div_exc ? S_DONE : S_ITER;
        else if (is_iterative(op)) state_nx = S_ITER;
        else                       state_nx = S_DONE;
      end
      S_ITER:  if (step_last) state_nx = (op == OP_DIV) ? S_CORR : S_DONE;
      S_CORR:  state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Shared WIDTH+1 adder; subtraction is a + ~b + 1
  always_comb begin
    add_a   = a;
    add_b   = {m[WIDTH-1], m};
    add_sub = 1'b0;
    case (op)
      OP_SUB: add_sub = 1'b1;
      OP_MUL: begin
        case ({q[0], q_m1})
          2'b01:   add_sub = 1'b0;
          2'b10:   add_sub = 1'b1;
          default: add_b   = '0;
        endcase
      end
      OP_DIV: begin
        add_b = {1'b0, m};
        if (state == S_ITER) begin
          add_a   = {a[WIDTH-1:0], q[WIDTH-1]};
          add_sub = ~a[WIDTH];
        end
      end
      default: ;
    endcase
    sum = add_a + (add_sub ? ~add_b : add_b) + {{WIDTH{1'b0}}, add_sub};
  end

  always_comb begin
    case (op)
      OP_MUL:  result = {a[WIDTH-1:0], q};
      OP_DIV:  result = exc ? {a[WIDTH-1:0], {WIDTH{1'b1}}} : {a[WIDTH-1:0], q};
      default: result = {{WIDTH{a[WIDTH-1]}}, a[WIDTH-1:0]};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op   <= OP_ADD;
      a    <= '0;
      q    <= '0;
      m    <= '0;
      q_m1 <= 1'b0;
      exc  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          op   <= op_t'(sel);
          q_m1 <= 1'b0;
          case (op_t'(sel))
            OP_DIV: begin
              a <= {1'b0, inbus[2*WIDTH-1:WIDTH]};
              q <= inbus[WIDTH-1:0];
            end
            OP_MUL: begin
              a <= '0;
              q <= inbus[WIDTH-1:0];
            end
            default: begin
              a <= {inbus[WIDTH-1], inbus[WIDTH-1:0]};
              q <= '0;
            end
          endcase
        end
        S_LOADM: m <= inbus[WIDTH-1:0];
        S_EXEC: begin
          exc <= (op == OP_DIV) && div_exc;
          if (!is_iterative(op)) a <= {sum[WIDTH-1], sum[WIDTH-1:0]};
        end
        S_ITER: begin
          if (op == OP_MUL) begin
            a    <= {sum[WIDTH], sum[WIDTH:1]};
            q    <= {sum[0], q[WIDTH-1:1]};
            q_m1 <= q[0];
          end else begin
            a <= sum;
            q <= {q[WIDTH-2:0], ~sum[WIDTH]};
          end
        end
        S_CORR: if (a[WIDTH]) a <= sum;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outbus <= '0;
      finish <= 1'b0;
    end else begin
      finish <= (state == S_DONE);
      if (state == S_DONE) outbus <= result;
    end
  end

`ifdef SEQ_ALU_STATUS_EN
  logic ovf_f, dz_f;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_f  <= 1'b0;
      dz_f   <= 1'b0;
      status <= 2'b00;
    end else begin
      if (state == S_EXEC) begin
        case (op)
          OP_ADD, OP_SUB: begin
            ovf_f <= sum[WIDTH] ^ sum[WIDTH-1];
            dz_f  <= 1'b0;
          end
          OP_DIV: begin
            ovf_f <= div_exc && (m != '0);
            dz_f  <= (m == '0);
          end
          default: begin
            ovf_f <= 1'b0;
            dz_f  <= 1'b0;
          end
        endcase
      end
      if (state == S_DONE) status <= pack_status(ovf_f, dz_f);
    end
  end
`endif

endmodule

// File: tb/tb_seq_alu_param.sv
// Directed and random bench for seq_alu_param (WIDTH=8 and WIDTH=16 instances).
// Define SEQ_ALU_STATUS_EN to also check the status output.
module tb_seq_alu_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_r;
  logic        unit;
  logic [1:0]  sel_r;
  logic [31:0] inbus_r;

  logic [15:0] ob8;
  logic [31:0] ob16;
  logic        fin8, fin16, bsy8, bsy16;
  logic        fin, bsy;
  logic [31:0] ob;

  logic [31:0] exp_q[$];
  logic [1:0]  st_q[$];
  int          checks = 0;
  int          errors = 0;

`ifdef SEQ_ALU_STATUS_EN
  logic [1:0] st8, st16, st;
  assign st = unit ? st16 : st8;
`endif

  always #5 clk = ~clk;

  seq_alu_param #(.WIDTH(8)) dut8 (
    .clk    (clk),
    .rst    (rst),
    .start  (start_r & ~unit),
    .sel    (sel_r),
    .inbus  (inbus_r[15:0]),
    .outbus (ob8),
    .finish (fin8),
    .busy   (bsy8)
`ifdef SEQ_ALU_STATUS_EN
    ,
    .status (st8)
`endif
  );

  seq_alu_param #(.WIDTH(16)) dut16 (
    .clk    (clk),
    .rst    (rst),
    .start  (start_r & unit),
    .sel    (sel_r),
    .inbus  (inbus_r),
    .outbus (ob16),
    .finish (fin16),
    .busy   (bsy16)
`ifdef SEQ_ALU_STATUS_EN
    ,
    .status (st16)
`endif
  );

  assign fin = unit ? fin16 : fin8;
  assign bsy = unit ? bsy16 : bsy8;
  assign ob  = unit ? ob16 : {16'h0, ob8};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model for the 8-bit instance
  task automatic model8(input logic [1:0] s, input logic [15:0] b1, input logic [7:0] b2,
                        output logic [31:0] r, output logic [1:0] stv, output int lat);
    logic [7:0]  x, d;
    logic [15:0] p, qq, rr;
    x = b1[7:0];
    stv = 2'b00;
    case (s)
      2'b00, 2'b01: begin
        d   = (s == 2'b00) ? x + b2 : x - b2;
        r   = {16'h0, {8{d[7]}}, d};
        lat = 3;
        if (s == 2'b00) stv[1] = (x[7] == b2[7]) && (d[7] != x[7]);
        else            stv[1] = (x[7] != b2[7]) && (d[7] != x[7]);
      end
      2'b10: begin
        p   = 16'($signed({{8{x[7]}}, x}) * $signed({{8{b2[7]}}, b2}));
        r   = {16'h0, p};
        lat = 11;
      end
      default: begin
        if (b2 == 8'd0 || b1[15:8] >= b2) begin
          r   = {16'h0, b1[15:8], 8'hFF};
          lat = 3;
          stv = (b2 == 8'd0) ? 2'b01 : 2'b10;
        end else begin
          qq  = b1 / {8'h0, b2};
          rr  = b1 % {8'h0, b2};
          r   = {16'h0, rr[7:0], qq[7:0]};
          lat = 12;
        end
      end
    endcase
  endtask

  task automatic run_op(input logic u, input logic [1:0] s, input logic [31:0] b1,
                        input logic [31:0] b2, input logic [31:0] exp_res,
                        input logic [1:0] exp_st, input int exp_lat, input bit poke);
    int lat;
    logic [31:0] e;
    exp_q.push_back(exp_res);
    st_q.push_back(exp_st);
    @(negedge clk);
    unit = u; start_r = 1'b1; sel_r = s; inbus_r = b1;
    @(posedge clk); #1;
    start_r = 1'b0; inbus_r = b2; sel_r = 2'($urandom_range(0, 3));
    check("busy_after_start", {31'h0, bsy}, 32'd1);
    lat = 0;
    while (lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (fin) break;
      start_r = poke && (lat == 4);
      if (lat >= 1) inbus_r = $urandom;
    end
    start_r = 1'b0;
    check("latency", lat, exp_lat);
    e = exp_q.pop_front();
    check("outbus", ob, e);
`ifdef SEQ_ALU_STATUS_EN
    check("status", {30'h0, st}, {30'h0, st_q.pop_front()});
`else
    void'(st_q.pop_front());
`endif
    check("busy_at_finish", {31'h0, bsy}, 32'd1);
    @(posedge clk); #1;
    check("finish_pulse", {31'h0, fin}, 32'd0);
    check("idle_busy", {31'h0, bsy}, 32'd0);
    check("outbus_held", ob, e);
  endtask

  initial begin
    logic [31:0] r;
    logic [1:0]  stv, s;
    logic [15:0] b1;
    logic [7:0]  b2;
    int          lat, fins;

    rst = 1'b1; start_r = 1'b0; unit = 1'b0; sel_r = 2'b00; inbus_r = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outbus8", {16'h0, ob8}, 32'd0);
    check("rst_outbus16", ob16, 32'd0);
    check("rst_finish", {30'h0, fin8, fin16}, 32'd0);
    check("rst_busy", {30'h0, bsy8, bsy16}, 32'd0);
    @(negedge clk) rst = 1'b0;

    run_op(0, 2'b00, 32'd40, 32'd12, 32'd52, 2'b00, 3, 0);
    run_op(0, 2'b01, 32'd40, 32'd12, 32'd28, 2'b00, 3, 0);
    run_op(0, 2'b01, 32'd12, 32'd40, 32'hFFE4, 2'b00, 3, 0);
    run_op(0, 2'b00, 32'd100, 32'd100, 32'hFFC8, 2'b10, 3, 0);
    run_op(0, 2'b10, 32'd40, 32'd12, 32'd480, 2'b00, 11, 0);
    run_op(0, 2'b10, 32'hFD, 32'd5, 32'hFFF1, 2'b00, 11, 0);
    run_op(0, 2'b10, 32'h80, 32'h80, 32'h4000, 2'b00, 11, 1);
    run_op(0, 2'b11, 32'd11542, 32'd135, 32'h4355, 2'b00, 12, 0);
    run_op(0, 2'b11, 32'd100, 32'd0, 32'h00FF, 2'b01, 3, 0);
    run_op(0, 2'b11, 32'h8712, 32'h50, 32'h87FF, 2'b10, 3, 0);

    for (int i = 0; i < 8; i++) begin
      s  = 2'($urandom_range(0, 3));
      b1 = 16'($urandom_range(0, 65535));
      b2 = 8'($urandom_range(0, 255));
      if (s == 2'b11 && (i % 2) == 0) b2 = b2 | 8'h80;
      if (s != 2'b11) b1[15:8] = 8'($urandom_range(0, 255));
      model8(s, b1, b2, r, stv, lat);
      run_op(0, s, {16'h0, b1}, {24'h0, b2}, r, stv, lat, 0);
    end

    // Reset in the middle of a multiply: no finish, outputs cleared
    @(negedge clk);
    unit = 1'b0; start_r = 1'b1; sel_r = 2'b10; inbus_r = 32'd40;
    @(posedge clk); #1;
    start_r = 1'b0; inbus_r = 32'd12;
    repeat (4) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1;
    check("midrst_outbus", {16'h0, ob8}, 32'd0);
    check("midrst_busy", {31'h0, bsy8}, 32'd0);
    check("midrst_finish", {31'h0, fin8}, 32'd0);
    @(negedge clk) rst = 1'b0;
    fins = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (fin8) fins++;
    end
    check("midrst_no_finish", fins, 32'd0);
    run_op(0, 2'b00, 32'd1, 32'd1, 32'd2, 2'b00, 3, 0);

    run_op(1, 2'b10, 32'd300, 32'h0000FFFE, 32'hFFFF_FDA8, 2'b00, 19, 1);
    run_op(1, 2'b11, 32'd1000000, 32'd1000, 32'h0000_03E8, 2'b00, 20, 0);
    run_op(1, 2'b01, 32'h8000, 32'd1, 32'h0000_7FFF, 2'b10, 3, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
